// File: rtl/cpu64_l2_pkg.sv
// Shared L2 definitions: geometry constants used by the arrays and the
// line-transfer sequencer, plus command and sequencer state encodings.
package cpu64_l2_pkg;

    localparam int L2_INDEX_W = 8;
    localparam int L2_WAY_W   = 4;
    localparam int L2_TAG_W   = 50;
    localparam int L2_DATA_W  = 64;
    localparam int L2_BEATS   = 8;

    typedef enum logic [1:0] {
        OP_NONE       = 2'b00,
        OP_FILL       = 2'b01,
        OP_EVICT      = 2'b10,
        OP_EVICT_FILL = 2'b11
    } xfer_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVICT = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/cpu64_l2_line_xfer.sv
// Whole-line mover in front of cpu64_l2_arrays: streams a victim line out as
// writeback beats and/or writes a refill line critical-word-first with wrap.
module cpu64_l2_line_xfer
    import cpu64_l2_pkg::*;
#(
    parameter int INDEX_W = L2_INDEX_W,
    parameter int WAY_W   = L2_WAY_W,
    parameter int TAG_W   = L2_TAG_W,
    parameter int DATA_W  = L2_DATA_W,
    parameter int BEATS   = L2_BEATS,
    localparam int WORD_W = $clog2(BEATS)
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [INDEX_W-1:0] cmd_index_i,
    input  logic [WAY_W-1:0]   cmd_way_i,
    input  logic [WORD_W-1:0]  cmd_word_i,
    input  logic [TAG_W-1:0]   cmd_tag_i,

    input  logic               fill_valid_i,
    output logic               fill_ready_o,
    input  logic [DATA_W-1:0]  fill_data_i,

    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [DATA_W-1:0]  wb_data_o,
    output logic [TAG_W-1:0]   wb_tag_o,
    output logic               wb_last_o,

    output logic               done_o,

    output logic [INDEX_W-1:0] arr_index_o,
    output logic [WAY_W-1:0]   arr_way_sel_o,
    output logic [WORD_W-1:0]  arr_word_sel_o,
    output logic               arr_write_en_o,
    output logic [7:0]         arr_be_o,
    output logic [TAG_W-1:0]   arr_tag_o,
    output logic [DATA_W-1:0]  arr_wdata_o,
    input  logic [DATA_W-1:0]  arr_rdata_i,
    input  logic [TAG_W-1:0]   arr_tag_i
);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BEATS - 1);

    xfer_state_e        state_q, state_d;
    xfer_op_e           op_q;
    logic [INDEX_W-1:0] index_q;
    logic [WAY_W-1:0]   way_q;
    logic [WORD_W-1:0]  word_q;
    logic [TAG_W-1:0]   tag_q;
    // word_ptr drives the array word address; beat_cnt counts accepted fill
    // beats independently so a wrapped critical-word start ends correctly.
    logic [WORD_W-1:0]  word_ptr_q, word_ptr_d;
    logic [WORD_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic               cmd_fire;
    logic               evict_last;

    assign cmd_fire       = cmd_valid_i && cmd_ready_o;
    assign evict_last     = (word_ptr_q == LAST_WORD);
    assign arr_index_o    = index_q;
    assign arr_way_sel_o  = way_q;
    assign arr_word_sel_o = word_ptr_q;

    always_comb begin
        state_d        = state_q;
        word_ptr_d     = word_ptr_q;
        beat_cnt_d     = beat_cnt_q;
        cmd_ready_o    = 1'b0;
        fill_ready_o   = 1'b0;
        wb_valid_o     = 1'b0;
        wb_data_o      = '0;
        wb_tag_o       = '0;
        wb_last_o      = 1'b0;
        done_o         = 1'b0;
        arr_write_en_o = 1'b0;
        arr_be_o       = '0;
        arr_tag_o      = '0;
        arr_wdata_o    = '0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    beat_cnt_d = '0;
                    word_ptr_d = (cmd_op_i == OP_FILL) ? cmd_word_i : '0;
                    case (cmd_op_i)
                        OP_FILL:                state_d = ST_FILL;
                        OP_EVICT, OP_EVICT_FILL: state_d = ST_EVICT;
                        default:                state_d = ST_DONE;
                    endcase
                end
            end
            ST_EVICT: begin
                wb_valid_o = 1'b1;
                wb_data_o  = arr_rdata_i;
                wb_tag_o   = arr_tag_i;
                wb_last_o  = evict_last;
                if (wb_ready_i) begin
                    word_ptr_d = word_ptr_q + 1'b1;
                    if (evict_last) begin
                        if (op_q == OP_EVICT_FILL) begin
                            state_d    = ST_FILL;
                            word_ptr_d = word_q;
                            beat_cnt_d = '0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_FILL: begin
                fill_ready_o = 1'b1;
                if (fill_valid_i) begin
                    arr_write_en_o = 1'b1;
                    arr_be_o       = 8'hFF;
                    arr_tag_o      = tag_q;
                    arr_wdata_o    = fill_data_i;
                    word_ptr_d     = word_ptr_q + 1'b1;
                    beat_cnt_d     = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_WORD) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NONE;
            index_q    <= '0;
            way_q      <= '0;
            word_q     <= '0;
            tag_q      <= '0;
            word_ptr_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_ptr_q <= word_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            if (cmd_fire) begin
                op_q    <= xfer_op_e'(cmd_op_i);
                index_q <= cmd_index_i;
                way_q   <= cmd_way_i;
                word_q  <= cmd_word_i;
                tag_q   <= cmd_tag_i;
            end
        end
    end

endmodule

// File: tb/tb_cpu64_l2_line_xfer.sv
// Directed bench for cpu64_l2_line_xfer with a behavioural array model:
// table of commands plus hand sequences for busy and mid-fill reset.
module tb_cpu64_l2_line_xfer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_index;
    logic [3:0]  cmd_way;
    logic [2:0]  cmd_word;
    logic [49:0] cmd_tag;
    logic        fill_valid;
    logic        fill_ready_o;
    logic [63:0] fill_data;
    logic        wb_valid_o;
    logic        wb_ready;
    logic [63:0] wb_data_o;
    logic [49:0] wb_tag_o;
    logic        wb_last_o;
    logic        done_o;
    logic [7:0]  arr_index_o;
    logic [3:0]  arr_way_sel_o;
    logic [2:0]  arr_word_sel_o;
    logic        arr_write_en_o;
    logic [7:0]  arr_be_o;
    logic [49:0] arr_tag_o;
    logic [63:0] arr_wdata_o;
    logic [63:0] arr_rdata;
    logic [49:0] arr_tag;

    bit [63:0] mem    [256][16][8];
    bit [49:0] tagmem [256][16];

    int errors = 0;
    int checks = 0;

    cpu64_l2_line_xfer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op),
        .cmd_index_i(cmd_index), .cmd_way_i(cmd_way), .cmd_word_i(cmd_word), .cmd_tag_i(cmd_tag),
        .fill_valid_i(fill_valid), .fill_ready_o(fill_ready_o), .fill_data_i(fill_data),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready), .wb_data_o(wb_data_o),
        .wb_tag_o(wb_tag_o), .wb_last_o(wb_last_o), .done_o(done_o),
        .arr_index_o(arr_index_o), .arr_way_sel_o(arr_way_sel_o), .arr_word_sel_o(arr_word_sel_o),
        .arr_write_en_o(arr_write_en_o), .arr_be_o(arr_be_o), .arr_tag_o(arr_tag_o),
        .arr_wdata_o(arr_wdata_o), .arr_rdata_i(arr_rdata), .arr_tag_i(arr_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: combinational read of the addressed word, write at the edge.
    assign arr_rdata = mem[arr_index_o][arr_way_sel_o][arr_word_sel_o];
    assign arr_tag   = tagmem[arr_index_o][arr_way_sel_o];
    always @(posedge clk) begin
        if (arr_write_en_o) begin
            mem[arr_index_o][arr_way_sel_o][arr_word_sel_o] <= arr_wdata_o;
            tagmem[arr_index_o][arr_way_sel_o]              <= arr_tag_o;
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  idx;
        logic [3:0]  way;
        logic [2:0]  word;
        logic [49:0] tag;
        logic [63:0] base;
        logic [63:0] fv_mask;   // fill_valid per cycle after accept (bit c = cycle N+c)
        logic [63:0] wr_mask;   // wb_ready per cycle after accept
        int          done_cyc;  // cycle after accept that shows done_o
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one command and follow it cycle by cycle until done_o.
    task automatic run_vec(input vec_t v);
        int  fk;
        int  ek;
        int  done_c;
        bit  ev_ph;
        bit  fi_ph;
        logic [2:0] wsel;
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_index = v.idx;
        cmd_way   = v.way;
        cmd_word  = v.word;
        cmd_tag   = v.tag;
        #1 chk("accept_ready", 64'(cmd_ready_o), 64'd1);
        tick();
        cmd_valid = 1'b0;
        fk = 0; ek = 0; done_c = 0;
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            ev_ph      = v.op[1] && (ek < 8);
            fi_ph      = v.op[0] && !ev_ph && (fk < 8);
            fill_valid = v.fv_mask[c];
            wb_ready   = v.wr_mask[c];
            fill_data  = v.base | 64'(fk);
            #1;
            chk("busy_ready", 64'(cmd_ready_o), 64'd0);
            chk("wb_valid", 64'(wb_valid_o), 64'(ev_ph));
            chk("fill_ready", 64'(fill_ready_o), 64'(fi_ph));
            chk("write_en", 64'(arr_write_en_o), 64'(fi_ph && fill_valid));
            chk("done", 64'(done_o), 64'(!ev_ph && !fi_ph));
            if (done_o) done_c = c;
            if (ev_ph) begin
                chk("wb_word_sel", 64'(arr_word_sel_o), 64'(ek));
                chk("wb_data", wb_data_o, mem[v.idx][v.way][ek]);
                chk("wb_tag", 64'(wb_tag_o), 64'(tagmem[v.idx][v.way]));
                chk("wb_last", 64'(wb_last_o), 64'(ek == 7));
                if (wb_ready) ek++;
            end
            if (fi_ph && fill_valid) begin
                wsel = v.word + 3'(fk);
                chk("fill_word_sel", 64'(arr_word_sel_o), 64'(wsel));
                chk("fill_index", 64'(arr_index_o), 64'(v.idx));
                chk("fill_way", 64'(arr_way_sel_o), 64'(v.way));
                chk("fill_wdata", arr_wdata_o, v.base | 64'(fk));
                chk("fill_tag", 64'(arr_tag_o), 64'(v.tag));
                chk("fill_be", 64'(arr_be_o), 64'hFF);
                fk++;
            end
            tick();
        end
        fill_valid = 1'b0;
        wb_ready   = 1'b0;
        chk("done_cycle", 64'(done_c), 64'(v.done_cyc));
        chk("fill_beats", 64'(fk), v.op[0] ? 64'd8 : 64'd0);
        chk("wb_beats", 64'(ek), v.op[1] ? 64'd8 : 64'd0);
        #1;
        chk("done_pulse_end", 64'(done_o), 64'd0);
        chk("ready_after_done", 64'(cmd_ready_o), 64'd1);
        if (v.op[0]) begin
            for (int k = 0; k < 8; k++) begin
                wsel = v.word + 3'(k);
                chk("line_word", mem[v.idx][v.way][wsel], v.base | 64'(k));
            end
            chk("line_tag", 64'(tagmem[v.idx][v.way]), 64'(v.tag));
        end
    endtask

    initial begin
        vec_t vr;
        bit   done_seen;
        rst_n      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_index  = '0;
        cmd_way    = '0;
        cmd_word   = '0;
        cmd_tag    = '0;
        fill_valid = 1'b0;
        fill_data  = '0;
        wb_ready   = 1'b0;

        vecs[0] = '{2'b01, 8'h10, 4'd5,  3'd2, 50'h123456789ABC, 64'hA5A5_0000_0000_0000, ~64'd0, ~64'd0, 9};
        vecs[1] = '{2'b01, 8'h11, 4'd3,  3'd7, 50'h0DEADBEEF01,  64'h1111_0000_0000_0000, ~64'h18, ~64'd0, 11};
        vecs[2] = '{2'b10, 8'h10, 4'd5,  3'd0, 50'h0,            64'h0, ~64'd0, 64'hAAAA_AAAA_AAAA_AAAA, 16};
        vecs[3] = '{2'b11, 8'h10, 4'd5,  3'd5, 50'h3_0000_0000_4321, 64'hBBBB_0000_0000_0000, ~64'd0, ~64'd0, 17};
        vecs[4] = '{2'b00, 8'h12, 4'd1,  3'd3, 50'h77,           64'h0, ~64'd0, ~64'd0, 1};
        vecs[5] = '{2'b01, 8'hFF, 4'd15, 3'd0, 50'h3_FFFF_FFFF_FFFF, 64'hCCCC_0000_0000_0000, ~64'd0, ~64'd0, 9};
        vecs[6] = '{2'b10, 8'hFF, 4'd15, 3'd0, 50'h0,            64'h0, ~64'd0, ~64'd0, 9};

        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_fill_ready", 64'(fill_ready_o), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_wb_last", 64'(wb_last_o), 64'd0);
        chk("rst_write_en", 64'(arr_write_en_o), 64'd0);
        chk("rst_be", 64'(arr_be_o), 64'd0);
        chk("rst_index", 64'(arr_index_o), 64'd0);
        chk("rst_way", 64'(arr_way_sel_o), 64'd0);
        chk("rst_word_sel", 64'(arr_word_sel_o), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Command held valid while busy: ignored until the first IDLE cycle.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_index = 8'h30; cmd_way = 4'd1;
        cmd_word = 3'd4; cmd_tag = 50'h111;
        #1 chk("busy_accept_ready", 64'(cmd_ready_o), 64'd1);
        tick();
        cmd_index = 8'h31; cmd_way = 4'd2; cmd_word = 3'd0; cmd_tag = 50'h222;
        fill_valid = 1'b1;
        done_seen  = 1'b0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            fill_data = 64'hD0D0_0000_0000_0000 | 64'(c);
            #1;
            chk("held_ready_low", 64'(cmd_ready_o), 64'd0);
            chk("held_index_kept", 64'(arr_index_o), 64'h30);
            if (done_o) done_seen = 1'b1;
            tick();
        end
        chk("held_done_seen", 64'(done_seen), 64'd1);
        fill_valid = 1'b0;
        #1 chk("held_ready_after_done", 64'(cmd_ready_o), 64'd1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("held_cmd_index", 64'(arr_index_o), 64'h31);
        chk("held_cmd_way", 64'(arr_way_sel_o), 64'd2);
        chk("held_cmd_fill_ready", 64'(fill_ready_o), 64'd1);
        for (int k = 0; k < 8; k++) begin
            fill_valid = 1'b1;
            fill_data  = 64'hE0E0_0000_0000_0000 | 64'(k);
            #1;
            chk("held_fill_we", 64'(arr_write_en_o), 64'd1);
            chk("held_fill_word", 64'(arr_word_sel_o), 64'(k));
            tick();
        end
        fill_valid = 1'b0;
        #1 chk("held_fill_done", 64'(done_o), 64'd1);
        tick();
        #1 chk("held_fill_idle", 64'(cmd_ready_o), 64'd1);
        chk("held_line_w7", mem[8'h31][2][7], 64'hE0E0_0000_0000_0007);

        // Reset after three fill beats aborts; a fresh FILL then completes.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_index = 8'h40; cmd_way = 4'd3;
        cmd_word = 3'd1; cmd_tag = 50'h5A5;
        #1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fill_valid = 1'b1;
            fill_data  = 64'h9999_0000_0000_0000 | 64'(k);
            #1;
            tick();
        end
        fill_valid = 1'b1;
        #1 chk("rst_mid_pre_we", 64'(arr_write_en_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 64'(arr_write_en_o), 64'd0);
        chk("rst_mid_fill_ready", 64'(fill_ready_o), 64'd0);
        chk("rst_mid_done", 64'(done_o), 64'd0);
        chk("rst_mid_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("rst_mid_word_sel", 64'(arr_word_sel_o), 64'd0);
        tick();
        rst_n      = 1'b1;
        fill_valid = 1'b0;
        #1 chk("rst_release_ready", 64'(cmd_ready_o), 64'd1);
        vr = '{2'b01, 8'h40, 4'd3, 3'd1, 50'h5A5, 64'h4444_0000_0000_0000, ~64'd0, ~64'd0, 9};
        run_vec(vr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu64_l2_line_xfer.md
# cpu64_l2_line_xfer

Line-transfer sequencer that sits directly upstream of `cpu64_l2_arrays` and owns its address, write and read ports during whole-line moves. It streams a 64 B refill line, as 8 × 64-bit beats, into a chosen set/way with critical-word-first wrap. It also reads a victim line out of the arrays as an 8-beat writeback stream. It can run both as one evict-then-refill command, and the L2 controller issues one command per miss.

## Interface
Parameters:
- INDEX_W, 8, set index width
- WAY_W, 4, way select width (16 ways)
- TAG_W, 50, tag width
- DATA_W, 64, beat/word width
- BEATS, 8, words per line; power of two

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when `cmd_valid_i && cmd_ready_o`
- cmd_op_i  in  2  command code: 01 FILL, 10 EVICT, 11 EVICT_FILL, 00 reserved (accepted, goes straight to DONE)
- cmd_index_i  in  INDEX_W  target set
- cmd_way_i  in  WAY_W  target way
- cmd_word_i  in  3  first fill word (critical word)
- cmd_tag_i  in  TAG_W  tag written during fill
- fill_valid_i / fill_ready_o / fill_data_i  in / out / in  1 / 1 / DATA_W  refill beat stream
- wb_valid_o / wb_ready_i  out / in  1 / 1  writeback beat handshake
- wb_data_o  out  DATA_W  writeback beat data
- wb_tag_o  out  TAG_W  victim tag
- wb_last_o  out  1  marks the last writeback beat
- done_o  out  1  one-cycle pulse when a command completes
- arr_index_o, arr_way_sel_o, arr_word_sel_o  out  INDEX_W, WAY_W, 3  array address
- arr_write_en_o, arr_be_o, arr_tag_o, arr_wdata_o  out  1, 8, TAG_W, DATA_W  array write port
- arr_rdata_i, arr_tag_i  in  DATA_W, TAG_W  array selected read data and tag; combinational from the address; writes commit at the clk edge

## Operation
- States: IDLE, EVICT, FILL, DONE.
- IDLE:
  - `cmd_ready_o` = 1.
  - On accept, capture op, index, way, word and tag into registers. The array address outputs come from these registers.
  - Next state: EVICT for op 10/11, FILL for op 01, DONE for op 00.
- EVICT:
  - The beat counter starts at 0 and `arr_word_sel_o` = counter.
  - `wb_valid_o` = 1; `wb_data_o` = `arr_rdata_i`; `wb_tag_o` = `arr_tag_i`; `wb_last_o` = 1 when counter = 7.
  - On `wb_valid_o && wb_ready_i` the counter increments.
  - After the transfer with `wb_last_o` = 1: go to FILL if op = 11, else go to DONE.
  - No array write occurs in EVICT.
- FILL:
  - The counter is loaded with `cmd_word` on entry. `arr_word_sel_o` = counter; the counter increments mod 8, so 7 wraps to 0.
  - `fill_ready_o` = 1.
  - Each cycle with `fill_valid_i` = 1:
    - `arr_write_en_o` = 1, `arr_be_o` = 8'hFF, `arr_wdata_o` = `fill_data_i`, `arr_tag_o` = captured tag.
    - Cycles without `fill_valid_i` produce no write.
  - After the 8th accepted beat, go to DONE. Beats are tracked by a separate 3-bit count, not by the word address.
- DONE: `done_o` = 1 for exactly one cycle, then go to IDLE.
- Outputs while idle or stalled:
  - `arr_write_en_o` = 0 in every state except FILL with `fill_valid_i` = 1.
  - `fill_ready_o` = 0 outside FILL.
  - `wb_valid_o` = 0 outside EVICT.
- Backpressure: while `wb_valid_o && !wb_ready_i`, the address and `wb_data_o`/`wb_last_o` are held stable.
- Busy: `cmd_valid_i` is ignored outside IDLE.
- Reset values:
  - state IDLE, counters 0.
  - `cmd_ready_o` = 1; every other output 0, including `done_o`, `wb_*`, `fill_ready_o` and all `arr_*` outputs.
- Reset mid-operation aborts the command. No partial-line recovery is performed, and the controller reissues the command.

## Timing
- Command accepted at edge N: FILL or EVICT is active from cycle N+1.
- FILL with no bubbles: 8 write cycles (N+1..N+8), `done_o` at N+9, `cmd_ready_o` at N+10.
- EVICT with `wb_ready_i` held at 1: beats at N+1..N+8, `done_o` at N+9.
- EVICT_FILL with no stalls: writeback N+1..N+8, fill N+9..N+16, `done_o` at N+17.
- `wb_data_o`, `fill_ready_o` and `arr_write_en_o` are combinational from state and handshake inputs. There is no extra register stage.

## Structure
- Shared package `cpu64_l2_pkg`:
  - op codes, state encoding;
  - INDEX_W, WAY_W, TAG_W, DATA_W, BEATS constants (shared with `cpu64_l2_arrays`).
- One module, no sub-modules. The counter and FSM are inline.

## Test plan
- FILL, idx 0x10, way 5, word 2, tag 0x123456789ABC, beats 0x..00–0x..07 with no gaps -> writes to words 2,3,4,5,6,7,0,1 in that order. Array word 2 = beat 0, word 1 = beat 7; `done_o` is a 1-cycle pulse at N+9.
- FILL with `fill_valid_i` deasserted on the 3rd and 4th cycles -> no write in the gap cycles; still exactly 8 writes; `done_o` is delayed by 2 cycles.
- EVICT, way 5, with `wb_ready_i` toggling 1,0,1,0… -> 8 transfers. `wb_data_o` is constant during stalls; `wb_last_o` is set only on word 7; `wb_tag_o` = 0x123456789ABC.
- EVICT_FILL on a prefilled line -> the 8 old words are streamed out before any write, then 8 new words are written. Exactly one `done_o` pulse is produced.
- `cmd_valid_i` held at 1 during a FILL -> `cmd_ready_o` = 0 and the command is not captured. It is accepted in the first IDLE cycle after `done_o`.
- `rst_n` asserted after 3 fill beats -> `arr_write_en_o`, `fill_ready_o` and `done_o` go to 0 immediately. `cmd_ready_o` = 1 after release, and a new FILL completes normally.
